// File: rtl/vproc_mem_arb_pkg.sv
// Shared types and defaults for the two-port VProc memory arbiter.
package vproc_mem_arb_pkg;

  localparam int          NPORTS     = 2;
  localparam int          MEM_AW_DEF = 10;
  localparam logic [3:0]  SEG_DEF    = 4'ha;
  localparam logic [31:0] OOS_RDATA  = 32'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vproc_mem_arbiter_rr_arb2.sv
// Two-requester round-robin grant logic; the last-grant history lives in the parent.
module rr_arb2
  import vproc_mem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic              last_grant,
  output logic [NPORTS-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/vproc_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between two VProc nodes,
// generating registered one-cycle write/read acknowledges.
//
// state  | meaning
// IDLE   | sample requests, latch winner into the memory strobes
// ACCESS | memory commits write / read data captured, ack registered
// ACK    | ack pulse visible to the winning node
module vproc_mem_arbiter
  import vproc_mem_arb_pkg::*;
#(
  parameter int         MEM_AW = MEM_AW_DEF,
  parameter logic [3:0] SEG    = SEG_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       p0_addr,
  input  logic              p0_we,
  input  logic              p0_rd,
  input  logic [3:0]        p0_be,
  input  logic [31:0]       p0_wdata,
  output logic [31:0]       p0_rdata,
  output logic              p0_wrack,
  output logic              p0_rdack,
  input  logic [31:0]       p1_addr,
  input  logic              p1_we,
  input  logic              p1_rd,
  input  logic [3:0]        p1_be,
  input  logic [31:0]       p1_wdata,
  output logic [31:0]       p1_rdata,
  output logic              p1_wrack,
  output logic              p1_rdack,
  output logic [MEM_AW-1:0] mem_a,
  output logic [31:0]       mem_di,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  output logic              mem_cs,
  input  logic [31:0]       mem_do,
  output logic [1:0]        err,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q;
  logic              win_q;
  logic              wr_q;
  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] gnt;
  logic              win;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_be;
  logic              sel_we;
  logic              sel_cs;

  assign req = {p1_we | p1_rd, p0_we | p0_rd};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign win       = gnt[1];
  assign sel_addr  = win ? p1_addr  : p0_addr;
  assign sel_wdata = win ? p1_wdata : p0_wdata;
  assign sel_be    = win ? p1_be    : p0_be;
  assign sel_we    = win ? p1_we    : p0_we;
  assign sel_cs    = (sel_addr[31:28] == SEG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ACCESS;
      ACCESS:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      wr_q         <= 1'b0;
      mem_a        <= '0;
      mem_di       <= '0;
      mem_be       <= '0;
      mem_we       <= 1'b0;
      mem_cs       <= 1'b0;
      err          <= '0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      p0_wrack     <= 1'b0;
      p0_rdack     <= 1'b0;
      p1_wrack     <= 1'b0;
      p1_rdack     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            win_q        <= win;
            last_grant_q <= win;
            wr_q         <= sel_we;
            mem_a        <= sel_addr[MEM_AW+1:2];
            mem_di       <= sel_wdata;
            mem_be       <= sel_be;
            mem_cs       <= sel_cs;
            mem_we       <= sel_we & sel_cs;
            if (!sel_cs) err[win] <= 1'b1;
          end
        end
        ACCESS: begin
          // mem_cs still reflects the segment match of this access here
          if (!wr_q) begin
            if (win_q) p1_rdata <= mem_cs ? mem_do : OOS_RDATA;
            else       p0_rdata <= mem_cs ? mem_do : OOS_RDATA;
          end
          p0_wrack <= ~win_q &  wr_q;
          p0_rdack <= ~win_q & ~wr_q;
          p1_wrack <=  win_q &  wr_q;
          p1_rdack <=  win_q & ~wr_q;
          mem_we   <= 1'b0;
          mem_cs   <= 1'b0;
        end
        default: begin
          p0_wrack <= 1'b0;
          p0_rdack <= 1'b0;
          p1_wrack <= 1'b0;
          p1_rdack <= 1'b0;
        end
      endcase
    end
  end

endmodule
